rr_stream_mux: RTL and testbench
================================

# rr_stream_mux

Parametrised successor to the team's combinational mux/demux pair: merges CHANNELS valid/ready input streams of WIDTH bits into one registered output stream. A round-robin arbiter picks the source. The selected channel index travels with the data so a downstream demux can route it back. An optional packet-lock mode holds the grant until the current packet completes. The block sits between the per-channel producers and the shared datapath in the Lab3 mux/demux chain.

## Interface
- WIDTH, 32, data bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥1, need not be a power of two)
- LOCK_MODE, 0, 0 = beat-level round-robin; 1 = grant held from first beat to in_last beat
- SEL_WIDTH, derived localparam, max(1, $clog2(CHANNELS))

Ports:
- clk  in  1  rising-edge clock, the block's only clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  WIDTH*CHANNELS  channel i occupies in_data[i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel beat valid
- in_last  in  CHANNELS  per-channel end-of-packet marker
- in_ready  out  CHANNELS  per-channel accept; at most one bit high
- out_data  out  WIDTH  registered selected beat
- out_valid  out  1  output beat valid
- out_last  out  1  registered in_last of the accepted beat
- out_chan  out  SEL_WIDTH  index of the source channel
- out_ready  in  1  downstream accept

## Operation
- Output stage: one-entry register. load_en = !out_valid | out_ready.
- Accept on channel i: in_valid[i] & in_ready[i]. Then in_ready[i] = grant[i] & load_en.
- Arbiter: grant goes to the first requesting channel, searching upward from ptr+1 modulo CHANNELS.
- ptr updates to the granted index only on an accept.
- With no requests, grant = 0 and ptr holds.
- On accept, out_data, out_last and out_chan load from the granted channel, and out_valid is set.
- On drain (out_valid & out_ready) with no accept, out_valid clears; data and chan hold their last values.
- Drain and accept in the same cycle: the register reloads and out_valid stays 1, with no bubble.
- LOCK_MODE=1 state machine:
  - ARB to LOCKED: on accept with in_last=0.
  - LOCKED to ARB: on accept with in_last=1.
  - In LOCKED, grant = ptr channel only. Other channels stall even if valid.
  - A single-beat packet (in_last=1 on the first beat) stays in ARB.
- LOCK_MODE=0: state stays in ARB; in_last is only forwarded.
- Producers must hold in_data, in_last and in_valid until accepted. Behaviour under a violation is undefined.

## Timing
- Reset values, while rst is high and after its release:
  - out_valid=0, out_data=0, out_last=0, out_chan=0
  - ptr=CHANNELS-1, so channel 0 has first priority
  - state=ARB
  - in_ready=0 (forced low while rst is asserted)
- Latency: a beat accepted at edge N is visible on out_* after edge N, i.e. one cycle.
- Throughput: one beat per cycle while out_ready=1.
- in_ready depends combinationally on out_ready, out_valid, in_valid and state. There is no combinational path from in_data to any output.
- Reset mid-packet clears the lock and drops any registered beat. There is no partial-packet recovery.
- CHANNELS=1: ptr and out_chan are constant 0, the arbiter degenerates, and lock mode still tracks in_last.
- Non-power-of-two CHANNELS: the modulo wrap skips unused indices, and out_chan never exceeds CHANNELS-1.

## Structure
- Shared header mux_pkg.vh holds:
  - the safe clog2 macro or function (minimum 1)
  - state encodings ST_ARB=1'b0 and ST_LOCKED=1'b1
- Sub-module rr_arbiter #(CHANNELS) with ports req, ptr, and one-hot grant plus grant_idx. It is purely combinational.
- ptr, state and the output register stay in rr_stream_mux.

## Test plan
Defaults for all scenarios are WIDTH=32 and CHANNELS=4 unless stated.

- **Reset**: assert rst mid-stream with out_valid=1 -> out_valid, out_data and out_chan go to 0 immediately. After release, the first grant with all channels valid goes to channel 0.
- **Fairness**: all 4 channels continuously valid with data i+1, out_ready=1 -> out_chan sequence is 0,1,2,3,0…; out_data is 1,2,3,4,1…; one beat per cycle.
- **Backpressure**: out_ready=0 for 3 cycles while all channels are valid -> out_data is held, in_ready is all 0, no beat is lost. On out_ready=1 the sequence resumes from the next channel.
- **Lock mode** (LOCK_MODE=1): channel 2 sends 3 beats, with in_last on the third, while channel 0 is valid throughout -> out_chan is 2,2,2 then 0. in_ready[0] stays 0 during the packet.
- **Sparse/wrap** (CHANNELS=3, WIDTH=18): only channels 2 and 0 are valid -> alternating out_chan 2,0,2; out_chan is never 3; data is 18'h2A5A5 passed intact.
- **Single channel** (CHANNELS=1, WIDTH=1): toggling in_valid -> out_chan is always 0, latency is 1 cycle, and there are no X values on out_*.

Source files
------------

// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for the round-robin stream mux: safe clog2 and lock FSM encodings.
package rr_stream_mux_pkg;

  // Select width never collapses to zero, even for a single channel.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational round-robin arbiter: first requester searching upward from ptr+1.
module rr_stream_mux_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_WIDTH = safe_clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0]  req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [CHANNELS-1:0]  grant,
  output logic [SEL_WIDTH-1:0] grant_idx
);

  int unsigned cand;
  logic        found;

  // Modulo wrap keeps the search inside 0..CHANNELS-1 for non-power-of-two counts.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 1; i <= int'(CHANNELS); i++) begin
      cand = (32'(ptr) + 32'(i)) % CHANNELS;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = SEL_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// Merges CHANNELS valid/ready streams into one registered output stream with
// round-robin arbitration and optional packet-level grant locking.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned LOCK_MODE = 0,
  localparam int unsigned SEL_WIDTH = safe_clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH*CHANNELS-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [SEL_WIDTH-1:0]      out_chan,
  input  logic                      out_ready
);

  logic [0:0]           state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [CHANNELS-1:0]  ptr_onehot;
  logic [CHANNELS-1:0]  req;
  logic [CHANNELS-1:0]  grant;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic                 load_en;
  logic                 accept;
  logic [WIDTH-1:0]     chan_data [CHANNELS];
  logic [WIDTH-1:0]     sel_data;
  logic                 sel_last;

  // While locked only the packet owner may request.
  always_comb begin
    ptr_onehot        = '0;
    ptr_onehot[ptr_q] = 1'b1;
    req = (state_q == ST_LOCKED) ? (in_valid & ptr_onehot) : in_valid;
  end

  rr_stream_mux_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arbiter (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign load_en  = !out_valid || out_ready;
  assign in_ready = rst ? '0 : (grant & {CHANNELS{load_en}});
  assign accept   = |(in_valid & in_ready);

  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end
    sel_data = chan_data[grant_idx];
    sel_last = in_last[grant_idx];
  end

  // Next-state: pointer follows accepted grants; lock spans first beat to last beat.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (accept) begin
      ptr_d = grant_idx;
      if (LOCK_MODE != 0) begin
        state_d = sel_last ? ST_ARB : ST_LOCKED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ARB;
      ptr_q     <= SEL_WIDTH'(CHANNELS - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_chan  <= grant_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed-vector bench for rr_stream_mux across default, lock, sparse and single-channel configs.
module tb_rr_stream_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // A: WIDTH=32, CHANNELS=4, beat-level round robin
  logic [127:0] a_in_data;
  logic [3:0]   a_in_valid, a_in_last, a_in_ready;
  logic [31:0]  a_out_data;
  logic         a_out_valid, a_out_last, a_out_ready;
  logic [1:0]   a_out_chan;

  // B: WIDTH=32, CHANNELS=4, packet lock
  logic [127:0] b_in_data;
  logic [3:0]   b_in_valid, b_in_last, b_in_ready;
  logic [31:0]  b_out_data;
  logic         b_out_valid, b_out_last, b_out_ready;
  logic [1:0]   b_out_chan;

  // C: WIDTH=18, CHANNELS=3
  logic [53:0]  c_in_data;
  logic [2:0]   c_in_valid, c_in_last, c_in_ready;
  logic [17:0]  c_out_data;
  logic         c_out_valid, c_out_last, c_out_ready;
  logic [1:0]   c_out_chan;

  // D: WIDTH=1, CHANNELS=1, lock mode tracking in_last
  logic         d_in_data, d_in_valid, d_in_last, d_in_ready;
  logic         d_out_data, d_out_valid, d_out_last, d_out_ready;
  logic         d_out_chan;

  rr_stream_mux #(.WIDTH(32), .CHANNELS(4), .LOCK_MODE(0)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_last(a_out_last), .out_chan(a_out_chan), .out_ready(a_out_ready));

  rr_stream_mux #(.WIDTH(32), .CHANNELS(4), .LOCK_MODE(1)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_last(b_out_last), .out_chan(b_out_chan), .out_ready(b_out_ready));

  rr_stream_mux #(.WIDTH(18), .CHANNELS(3), .LOCK_MODE(0)) u_dut_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_last(c_in_last),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid),
    .out_last(c_out_last), .out_chan(c_out_chan), .out_ready(c_out_ready));

  rr_stream_mux #(.WIDTH(1), .CHANNELS(1), .LOCK_MODE(1)) u_dut_d (
    .clk(clk), .rst(rst), .in_data(d_in_data), .in_valid(d_in_valid), .in_last(d_in_last),
    .in_ready(d_in_ready), .out_data(d_out_data), .out_valid(d_out_valid),
    .out_last(d_out_last), .out_chan(d_out_chan), .out_ready(d_out_ready));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    a_in_data   = {32'd4, 32'd3, 32'd2, 32'd1};
    a_in_valid  = 4'hF;
    a_in_last   = 4'h0;
    a_out_ready = 1'b1;
    b_in_data   = '0; b_in_valid = '0; b_in_last = '0; b_out_ready = 1'b1;
    c_in_data   = '0; c_in_valid = '0; c_in_last = '0; c_out_ready = 1'b1;
    d_in_data   = 1'b0; d_in_valid = 1'b0; d_in_last = 1'b0; d_out_ready = 1'b1;
    #1;
    check("rst_a_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_data",  64'(a_out_data),  64'd0);
    check("rst_a_chan",  64'(a_out_chan),  64'd0);
    check("rst_a_ready", 64'(a_in_ready),  64'd0);
    check("rst_d_valid", 64'(d_out_valid), 64'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("first_grant", 64'(a_in_ready), 64'h1);

    // Fairness: all channels valid, one beat per cycle in rotation.
    for (int k = 0; k < 6; k++) begin
      tick();
      check("fair_chan",  64'(a_out_chan),  64'(k % 4));
      check("fair_data",  64'(a_out_data),  64'((k % 4) + 1));
      check("fair_valid", 64'(a_out_valid), 64'd1);
    end
    check("fair_last", 64'(a_out_last), 64'd0);

    // Backpressure: register holds chan1 beat, nobody is accepted.
    a_out_ready = 1'b0;
    #1;
    check("bp_ready0", 64'(a_in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_data",  64'(a_out_data),  64'd2);
      check("bp_chan",  64'(a_out_chan),  64'd1);
      check("bp_valid", 64'(a_out_valid), 64'd1);
      check("bp_ready", 64'(a_in_ready),  64'd0);
    end
    a_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("resume_chan", 64'(a_out_chan), 64'((k + 2) % 4));
      check("resume_data", 64'(a_out_data), 64'(((k + 2) % 4) + 1));
    end

    // Drain without accept: valid drops, payload holds.
    a_in_valid = 4'h0;
    tick();
    check("drain_valid", 64'(a_out_valid), 64'd0);
    check("drain_data",  64'(a_out_data),  64'd1);
    check("drain_chan",  64'(a_out_chan),  64'd0);

    // Reset mid-stream.
    a_in_valid = 4'b0100;
    tick();
    check("pre_rst_chan", 64'(a_out_chan), 64'd2);
    check("pre_rst_data", 64'(a_out_data), 64'd3);
    a_in_valid = 4'hF;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(a_out_valid), 64'd0);
    check("mid_rst_data",  64'(a_out_data),  64'd0);
    check("mid_rst_chan",  64'(a_out_chan),  64'd0);
    check("mid_rst_ready", 64'(a_in_ready),  64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_grant", 64'(a_in_ready), 64'h1);
    tick();
    check("post_rst_chan", 64'(a_out_chan), 64'd0);
    check("post_rst_data", 64'(a_out_data), 64'd1);
    a_in_valid = 4'h0;
    tick();

    // Lock mode: single-beat ch1 packet moves ptr, then ch2 owns a 3-beat packet.
    b_in_data  = {32'h0, 32'h201, 32'h111, 32'h100};
    b_in_last  = 4'b0011;
    b_in_valid = 4'b0010;
    tick();
    check("lk_single_chan", 64'(b_out_chan), 64'd1);
    check("lk_single_last", 64'(b_out_last), 64'd1);
    b_in_valid = 4'b0101;
    #1;
    check("lk_grant2", 64'(b_in_ready), 64'b0100);
    tick();
    check("lk_b1_chan", 64'(b_out_chan), 64'd2);
    check("lk_b1_data", 64'(b_out_data), 64'h201);
    check("lk_b1_last", 64'(b_out_last), 64'd0);
    b_in_data[95:64] = 32'h202;
    #1;
    check("lk_stall_ch0", 64'(b_in_ready), 64'b0100);
    tick();
    check("lk_b2_chan", 64'(b_out_chan), 64'd2);
    check("lk_b2_data", 64'(b_out_data), 64'h202);
    b_in_valid = 4'b0001;
    #1;
    check("lk_gap_ready", 64'(b_in_ready), 64'd0);
    tick();
    check("lk_gap_valid", 64'(b_out_valid), 64'd0);
    b_in_valid = 4'b0101;
    b_in_data[95:64] = 32'h203;
    b_in_last[2] = 1'b1;
    #1;
    check("lk_b3_ready", 64'(b_in_ready), 64'b0100);
    tick();
    check("lk_b3_chan", 64'(b_out_chan), 64'd2);
    check("lk_b3_data", 64'(b_out_data), 64'h203);
    check("lk_b3_last", 64'(b_out_last), 64'd1);
    b_in_valid = 4'b0001;
    #1;
    check("lk_unlock_ready", 64'(b_in_ready), 64'b0001);
    tick();
    check("lk_ch0_chan", 64'(b_out_chan), 64'd0);
    check("lk_ch0_data", 64'(b_out_data), 64'h100);
    b_in_valid = 4'b0000;
    tick();

    // Sparse / wrap with three channels, only 2 and 0 active.
    c_in_data  = {18'h2A5A5, 18'h0, 18'h15A5A};
    c_in_valid = 3'b100;
    #1;
    check("sp_ready2", 64'(c_in_ready), 64'b100);
    tick();
    check("sp_first_chan", 64'(c_out_chan), 64'd2);
    check("sp_first_data", 64'(c_out_data), 64'h2A5A5);
    c_in_valid = 3'b101;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("sp_chan", 64'(c_out_chan), (k % 2 == 0) ? 64'd0 : 64'd2);
      check("sp_data", 64'(c_out_data), (k % 2 == 0) ? 64'h15A5A : 64'h2A5A5);
      check("sp_valid", 64'(c_out_valid), 64'd1);
    end
    check("sp_last", 64'(c_out_last), 64'd0);
    c_in_valid = 3'b000;
    tick();

    // Single channel with toggling valid.
    d_in_valid = 1'b1;
    d_in_data  = 1'b1;
    d_in_last  = 1'b0;
    #1;
    check("one_ready", 64'(d_in_ready), 64'd1);
    tick();
    check("one_valid1", 64'(d_out_valid), 64'd1);
    check("one_data1",  64'(d_out_data),  64'd1);
    check("one_chan1",  64'(d_out_chan),  64'd0);
    check("one_last1",  64'(d_out_last),  64'd0);
    d_in_valid = 1'b0;
    tick();
    check("one_idle_valid", 64'(d_out_valid), 64'd0);
    check("one_idle_data",  64'(d_out_data),  64'd1);
    d_in_valid = 1'b1;
    d_in_data  = 1'b0;
    d_in_last  = 1'b1;
    tick();
    check("one_valid2", 64'(d_out_valid), 64'd1);
    check("one_data2",  64'(d_out_data),  64'd0);
    check("one_last2",  64'(d_out_last),  64'd1);
    check("one_chan2",  64'(d_out_chan),  64'd0);
    d_in_valid = 1'b0;
    tick();
    check("one_end_valid", 64'(d_out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
